// File: rtl/dsp_mac_sequencer_pkg.sv
// Shared definitions for the DSP48A1 MAC sequencer: widths, OPMODE codes,
// FSM states and the per-operand tag carried alongside the slice pipeline.
package dsp_pkg;

    localparam int OPND_W = 18;
    localparam int ACC_W  = 48;

    localparam logic [7:0] OPM_MUL  = 8'h01;  // X=M, Z=0: start a new sum
    localparam logic [7:0] OPM_MAC  = 8'h09;  // X=M, Z=P: accumulate
    localparam logic [7:0] OPM_IDLE = 8'h00;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        HOLD  = 2'd3
    } state_t;

    typedef struct packed {
        logic valid;
        logic first;
        logic last;
    } tag_t;

    localparam tag_t TAG_NONE = '0;

    // OPMODE for the product entering the M stage, chosen by its tag.
    function automatic logic [7:0] opmode_for(input tag_t t);
        logic [7:0] opm;
        if (!t.valid) begin
            opm = OPM_IDLE;
        end else if (t.first) begin
            opm = OPM_MUL;
        end else begin
            opm = OPM_MAC;
        end
        return opm;
    endfunction

    // True when the tag marks the final product of a job.
    function automatic logic is_final(input tag_t t);
        return t.valid & t.last;
    endfunction

endpackage

// File: rtl/dsp_mac_sequencer_if.sv
// Job control, operand stream and result handshake of the MAC sequencer.
// master = operand source / result consumer, slave = sequencer.
interface dsp_mac_sequencer_if import dsp_pkg::*; #(
    parameter int CNT_W = 8
) ();

    logic              start;
    logic [CNT_W-1:0]  n_taps;
    logic              busy;
    logic              op_valid;
    logic              op_ready;
    logic [OPND_W-1:0] op_a;
    logic [OPND_W-1:0] op_b;
    logic              res_valid;
    logic              res_ready;
    logic [ACC_W-1:0]  res_data;

    modport master (
        output start, n_taps, op_valid, op_a, op_b, res_ready,
        input  busy, op_ready, res_valid, res_data
    );

    modport slave (
        input  start, n_taps, op_valid, op_a, op_b, res_ready,
        output busy, op_ready, res_valid, res_data
    );

endinterface

// File: rtl/dsp_mac_sequencer_tag_pipe.sv
// Shift register of {valid, first, last} tags that moves in lock-step with
// the slice pipeline (same enable), so control decisions follow the data.
module dsp_tag_pipe import dsp_pkg::*; #(
    parameter int DEPTH    = 3,
    parameter int TAP_OPM  = 1,
    parameter int TAP_POST = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  tag_t tag_in,
    output tag_t tap_opm,
    output tag_t tap_post
);

    tag_t [DEPTH-1:0] stage_r;

    // Advance every stage together whenever the slice advances.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_r <= '0;
        end else if (en) begin
            stage_r <= {stage_r[DEPTH-2:0], tag_in};
        end
    end

    assign tap_opm  = stage_r[TAP_OPM];
    assign tap_post = stage_r[TAP_POST];

endmodule

// File: rtl/dsp_mac_sequencer.sv
// Drives a DSP48A1 slice (A1/B1/M/P/OPMODE registered) to accumulate n_taps
// signed 18x18 products and returns the final P through a held handshake.
// All slice enables follow 'advance', so an operand bubble freezes the slice
// and the tag pipe together and cannot disturb the running sum.
module dsp_mac_sequencer import dsp_pkg::*; #(
    parameter int CNT_W        = 8,
    parameter int DSP_LATENCY  = 3,
    parameter int OPMODE_DELAY = 1
) (
    input  logic                 CLK,
    input  logic                 RST,
    dsp_mac_sequencer_if.slave   bus,
    output logic [OPND_W-1:0]    A,
    output logic [OPND_W-1:0]    B,
    output logic [7:0]           OPMODE,
    output logic                 CEA,
    output logic                 CEB,
    output logic                 CEM,
    output logic                 CEOPMODE,
    output logic                 CEP,
    input  logic [ACC_W-1:0]     P
);

    localparam logic [CNT_W-1:0] ONE_TAP = CNT_W'(1'b1);

    state_t            state_r;
    logic [CNT_W-1:0]  remaining_r;
    logic              first_r;
    logic              busy_r;
    logic              op_ready_r;
    logic [OPND_W-1:0] a_r;
    logic [OPND_W-1:0] b_r;
    logic              res_valid_r;
    logic [ACC_W-1:0]  res_data_r;
    logic              final_r;      // final product was added into P last edge

    logic accept_s;
    logic advance_s;
    tag_t tag_in_s;
    tag_t tap_opm_s;
    tag_t tap_post_s;

    assign accept_s = op_ready_r & bus.op_valid;

    // Pipeline advance and the tag describing the operand being accepted.
    always_comb begin
        advance_s = 1'b0;
        tag_in_s  = TAG_NONE;
        if (state_r == DRAIN) begin
            advance_s = 1'b1;
        end else begin
            advance_s = accept_s;
        end
        if (accept_s) begin
            tag_in_s.valid = 1'b1;
            tag_in_s.first = first_r;
            tag_in_s.last  = (remaining_r == ONE_TAP);
        end else begin
            tag_in_s = TAG_NONE;
        end
    end

    dsp_tag_pipe #(
        .DEPTH    (DSP_LATENCY),
        .TAP_OPM  (OPMODE_DELAY),
        .TAP_POST (DSP_LATENCY - 1)
    ) u_tag_pipe (
        .clk      (CLK),
        .rst      (RST),
        .en       (advance_s),
        .tag_in   (tag_in_s),
        .tap_opm  (tap_opm_s),
        .tap_post (tap_post_s)
    );

    // Job FSM, operand registers and result capture.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r     <= IDLE;
            remaining_r <= '0;
            first_r     <= 1'b0;
            busy_r      <= 1'b0;
            op_ready_r  <= 1'b0;
            a_r         <= '0;
            b_r         <= '0;
            res_valid_r <= 1'b0;
            res_data_r  <= '0;
            final_r     <= 1'b0;
        end else begin
            final_r <= advance_s & is_final(tap_post_s);
            if (accept_s) begin
                a_r <= bus.op_a;
                b_r <= bus.op_b;
            end
            case (state_r)
                IDLE: begin
                    if (bus.start && (bus.n_taps != '0)) begin
                        remaining_r <= bus.n_taps;
                        first_r     <= 1'b1;
                        busy_r      <= 1'b1;
                        op_ready_r  <= 1'b1;
                        state_r     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (accept_s) begin
                        remaining_r <= remaining_r - ONE_TAP;
                        first_r     <= 1'b0;
                        if (remaining_r == ONE_TAP) begin
                            op_ready_r <= 1'b0;
                            state_r    <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    // P was updated with the last product on the previous edge.
                    if (final_r) begin
                        res_data_r  <= P;
                        res_valid_r <= 1'b1;
                        state_r     <= HOLD;
                    end
                end
                HOLD: begin
                    if (bus.res_ready) begin
                        res_valid_r <= 1'b0;
                        busy_r      <= 1'b0;
                        state_r     <= IDLE;
                    end
                end
                default: begin
                    op_ready_r  <= 1'b0;
                    busy_r      <= 1'b0;
                    res_valid_r <= 1'b0;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

    assign A            = a_r;
    assign B            = b_r;
    assign CEA          = advance_s;
    assign CEB          = advance_s;
    assign CEM          = advance_s;
    assign CEOPMODE     = advance_s;
    assign CEP          = advance_s & tap_post_s.valid;
    assign OPMODE       = opmode_for(tap_opm_s);
    assign bus.busy      = busy_r;
    assign bus.op_ready  = op_ready_r;
    assign bus.res_valid = res_valid_r;
    assign bus.res_data  = res_data_r;

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Bench for dsp_mac_sequencer: a behavioural DSP48A1 slice (A1/B1/M/P/OPMODE
// registered) closes the loop on P; expected results are plain sums of
// signed products computed from the operand tables.
module tb_dsp_mac_sequencer;

    logic        CLK = 1'b0;
    logic        RST;
    logic [17:0] A;
    logic [17:0] B;
    logic [7:0]  OPMODE;
    logic        CEA, CEB, CEM, CEOPMODE, CEP;
    logic [47:0] P;

    always #5 CLK = ~CLK;

    dsp_mac_sequencer_if #(.CNT_W(8)) bus ();

    dsp_mac_sequencer dut (
        .CLK      (CLK),
        .RST      (RST),
        .bus      (bus),
        .A        (A),
        .B        (B),
        .OPMODE   (OPMODE),
        .CEA      (CEA),
        .CEB      (CEB),
        .CEM      (CEM),
        .CEOPMODE (CEOPMODE),
        .CEP      (CEP),
        .P        (P)
    );

    // Behavioural slice: A1/B1 -> M (signed 18x18) -> P with registered OPMODE.
    logic [17:0]        a1_q  = 18'd0;
    logic [17:0]        b1_q  = 18'd0;
    logic signed [35:0] m_q   = 36'sd0;
    logic [7:0]         opm_q = 8'd0;
    logic [47:0]        p_q   = 48'd0;
    assign P = p_q;

    always @(posedge CLK) begin
        if (CEA) a1_q <= A;
        if (CEB) b1_q <= B;
        if (CEM) m_q <= $signed(a1_q) * $signed(b1_q);
        if (CEOPMODE) opm_q <= OPMODE;
        if (CEP) p_q <= ((opm_q[3:2] == 2'b10) ? p_q : 48'd0)
                      + ((opm_q[1:0] == 2'b01) ? {{12{m_q[35]}}, m_q} : 48'd0);
    end

    int          vectors    = 0;
    int          miscompares = 0;
    logic [7:0]  opm_seen[$];
    logic [17:0] pa[16];
    logic [17:0] pb[16];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Sample the current cycle's slice controls, then move to the next negedge.
    task automatic step();
        #1;
        if (CEOPMODE === 1'b1 && OPMODE !== 8'h00) opm_seen.push_back(OPMODE);
        @(negedge CLK);
    endtask

    function automatic logic [47:0] ref_sum(input int n);
        longint s;
        s = 0;
        for (int i = 0; i < n; i++) begin
            s += longint'($signed(pa[i])) * longint'($signed(pb[i]));
        end
        return s[47:0];
    endfunction

    task automatic run_job(input int n, input int gap, input bit rand_gap,
                           input int hold, input string name);
        logic [47:0] exp;
        int lat;
        int g;
        exp = ref_sum(n);
        opm_seen.delete();
        bus.res_ready = (hold == 0);
        bus.start  = 1'b1;
        bus.n_taps = 8'(n);
        step();
        bus.start  = 1'b0;
        check({name, "_busy"}, 64'(bus.busy), 64'd1);
        for (int i = 0; i < n; i++) begin
            bus.op_valid = 1'b1;
            bus.op_a = pa[i];
            bus.op_b = pb[i];
            #1;
            check({name, "_ce_on"}, 64'({CEA, CEB, CEM, CEOPMODE}), 64'hF);
            step();
            bus.op_valid = 1'b0;
            g = rand_gap ? int'($urandom_range(0, 2)) : gap;
            if (i != n - 1) begin
                for (int k = 0; k < g; k++) begin
                    #1;
                    check({name, "_ce_gap"}, 64'({CEA, CEB, CEM, CEOPMODE, CEP}), 64'd0);
                    step();
                end
            end
        end
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (bus.res_valid === 1'b1) begin
                lat = k;
                break;
            end
        end
        check({name, "_latency"}, 64'(lat), 64'd4);
        check({name, "_res_data"}, 64'(bus.res_data), 64'(exp));
        check({name, "_opm_count"}, 64'(opm_seen.size()), 64'(n));
        for (int j = 0; j < opm_seen.size(); j++) begin
            check({name, "_opmode"}, 64'(opm_seen[j]), (j == 0) ? 64'h01 : 64'h09);
        end
        for (int k = 0; k < hold; k++) begin
            bus.start  = 1'b1;
            bus.n_taps = 8'd1;
            step();
            check({name, "_hold_valid"}, 64'(bus.res_valid), 64'd1);
            check({name, "_hold_data"}, 64'(bus.res_data), 64'(exp));
            check({name, "_hold_busy"}, 64'(bus.busy), 64'd1);
        end
        bus.res_ready = 1'b1;
        bus.start = (hold != 0);
        step();
        bus.start = 1'b0;
        check({name, "_hs_valid"}, 64'(bus.res_valid), 64'd0);
        check({name, "_hs_busy"}, 64'(bus.busy), 64'd0);
        step();
        check({name, "_idle_busy"}, 64'(bus.busy), 64'd0);
    endtask

    initial begin
        int seen;
        int n;
        bus.start = 1'b0;
        bus.n_taps = 8'd0;
        bus.op_valid = 1'b0;
        bus.op_a = 18'd0;
        bus.op_b = 18'd0;
        bus.res_ready = 1'b1;
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        check("rst_ab", 64'({A, B}), 64'd0);
        check("rst_ctl", 64'({OPMODE, CEA, CEB, CEM, CEOPMODE, CEP,
                              bus.busy, bus.op_ready, bus.res_valid}), 64'd0);
        check("rst_res", 64'(bus.res_data), 64'd0);
        RST = 1'b0;
        step();

        // Single tap: 3*4
        pa[0] = 18'd3; pb[0] = 18'd4;
        run_job(1, 0, 1'b0, 0, "single");

        // Four taps back-to-back: 1*2+3*4+5*6+7*8
        for (int i = 0; i < 4; i++) begin
            pa[i] = 18'(2 * i + 1);
            pb[i] = 18'(2 * i + 2);
        end
        run_job(4, 0, 1'b0, 0, "four");
        run_job(4, 2, 1'b0, 0, "stall");

        // Signed operands
        pa[0] = 18'h3FFFE; pb[0] = 18'd5;
        pa[1] = 18'd3;     pb[1] = 18'd3;
        run_job(2, 0, 1'b0, 0, "signed");
        pa[0] = 18'h20000; pb[0] = 18'h20000;
        run_job(1, 0, 1'b0, 0, "minmin");

        // Backpressure on the result, then an independent job
        for (int i = 0; i < 4; i++) begin
            pa[i] = 18'(2 * i + 1);
            pb[i] = 18'(2 * i + 2);
        end
        run_job(4, 0, 1'b0, 5, "backpr");
        pa[0] = 18'd2; pb[0] = 18'd3;
        run_job(1, 0, 1'b0, 0, "after_bp");

        // Reset in the middle of issuing a four-tap job
        bus.start = 1'b1;
        bus.n_taps = 8'd4;
        step();
        bus.start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.op_valid = 1'b1;
            bus.op_a = 18'(i + 5);
            bus.op_b = 18'(i + 7);
            step();
        end
        bus.op_valid = 1'b0;
        RST = 1'b1;
        #1;
        check("midrst_ab", 64'({A, B}), 64'd0);
        check("midrst_ctl", 64'({OPMODE, CEA, CEB, CEM, CEOPMODE, CEP,
                                 bus.busy, bus.op_ready, bus.res_valid}), 64'd0);
        @(negedge CLK);
        RST = 1'b0;
        seen = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (bus.res_valid === 1'b1) seen++;
        end
        check("midrst_no_result", 64'(seen), 64'd0);
        pa[0] = 18'd2; pb[0] = 18'd2;
        run_job(1, 0, 1'b0, 0, "post_rst");

        // Zero-tap start is ignored
        bus.start = 1'b1;
        bus.n_taps = 8'd0;
        step();
        bus.start = 1'b0;
        check("zero_busy", 64'(bus.busy), 64'd0);
        check("zero_ready", 64'(bus.op_ready), 64'd0);
        step();
        check("zero_busy2", 64'(bus.busy), 64'd0);

        // Randomized jobs with random bubbles
        for (int r = 0; r < 6; r++) begin
            n = int'($urandom_range(1, 8));
            for (int i = 0; i < n; i++) begin
                pa[i] = 18'($urandom());
                pb[i] = 18'($urandom());
            end
            run_job(n, 0, 1'b1, 0, "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
